// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid buffer.
// in_ready comes only from the skid valid bit and reset, so out_ready never reaches it combinationally.
module id_ex_skid_reg #(
    parameter int XLEN    = 64,
    parameter int FUNCT_W = 4,
    parameter int RD_W    = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    PC,
    input  logic [XLEN-1:0]    Read_Data_1,
    input  logic [XLEN-1:0]    Read_Data_2,
    input  logic [XLEN-1:0]    imm_value,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [RD_W-1:0]    RD,
    input  logic [ALUOP_W-1:0] ALU_OP,
    input  logic               MemtoReg,
    input  logic               RegWrite,
    input  logic               Branch,
    input  logic               MemWrite,
    input  logic               MemRead,
    input  logic               ALUSrc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    PC_Stored,
    output logic [XLEN-1:0]    Read_Data_1_S,
    output logic [XLEN-1:0]    Read_Data_2_S,
    output logic [XLEN-1:0]    imm_value_S,
    output logic [FUNCT_W-1:0] Funct_S,
    output logic [RD_W-1:0]    RD_S,
    output logic [ALUOP_W-1:0] ALU_OP_S,
    output logic               MemtoReg_S,
    output logic               RegWrite_S,
    output logic               Branch_S,
    output logic               MemWrite_S,
    output logic               MemRead_S,
    output logic               ALUSrc_S,
    output logic [1:0]         occupancy
);

    localparam int PW = 4*XLEN + FUNCT_W + RD_W + ALUOP_W + 6;

    // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   out_data_reg, out_data_next;
    logic [PW-1:0]   skid_data_reg, skid_data_next;
    logic [PW-1:0]   in_data;
    logic            skid_valid;
    logic            accept;
    logic            fire;
    logic [3:0]      ctrl_raw;
    logic [3:0]      ctrl_gated;

    assign in_data = {PC, Read_Data_1, Read_Data_2, imm_value, Funct, RD, ALU_OP,
                      MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc};

    assign out_valid  = state_reg[1];
    assign skid_valid = state_reg[0];
    assign in_ready   = !skid_valid && !reset;
    assign accept     = in_valid && in_ready;
    assign fire       = out_valid && out_ready;
    assign occupancy  = {1'b0, out_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            out_data_reg  <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            out_data_reg  <= out_data_next;
            skid_data_reg <= skid_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_data_next  = out_data_reg;
        skid_data_next = skid_data_reg;
        // Payload is not loaded on flush so a squashed bundle never shows on the ungated outputs.
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next    = ONE;
                        out_data_next = in_data;
                    end
                end
                ONE: begin
                    if (accept && fire) begin
                        out_data_next = in_data;
                    end else if (accept) begin
                        state_next     = FULL;
                        skid_data_next = in_data;
                    end else if (fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_next    = ONE;
                        out_data_next = skid_data_reg;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    assign {PC_Stored, Read_Data_1_S, Read_Data_2_S, imm_value_S, Funct_S, RD_S, ALU_OP_S,
            MemtoReg_S, ctrl_raw, ALUSrc_S} = out_data_reg;

    // Side-effecting controls must read as a bubble whenever the output entry is empty.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ctrl_gate
            assign ctrl_gated[gi] = ctrl_raw[gi] & out_valid;
        end
    endgenerate

    assign {RegWrite_S, Branch_S, MemWrite_S, MemRead_S} = ctrl_gated;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Randomized bench for id_ex_skid_reg, compared each cycle against a queue-based FIFO model.
module tb_id_ex_skid_reg;

    localparam int XLEN    = 64;
    localparam int FUNCT_W = 4;
    localparam int RD_W    = 5;
    localparam int ALUOP_W = 2;
    localparam int PW      = 4*XLEN + FUNCT_W + RD_W + ALUOP_W + 6;
    localparam int CW      = 280;

    logic               clk;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    PC, Read_Data_1, Read_Data_2, imm_value;
    logic [FUNCT_W-1:0] Funct;
    logic [RD_W-1:0]    RD;
    logic [ALUOP_W-1:0] ALU_OP;
    logic               MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    PC_Stored, Read_Data_1_S, Read_Data_2_S, imm_value_S;
    logic [FUNCT_W-1:0] Funct_S;
    logic [RD_W-1:0]    RD_S;
    logic [ALUOP_W-1:0] ALU_OP_S;
    logic               MemtoReg_S, RegWrite_S, Branch_S, MemWrite_S, MemRead_S, ALUSrc_S;
    logic [1:0]         occupancy;

    logic [PW-1:0]      din;
    logic [PW-1:0]      dout;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bundles held, oldest first, plus what the output registers last showed.
    logic [PW-1:0] q[$];
    logic [PW-1:0] last_shown = '0;

    assign {PC, Read_Data_1, Read_Data_2, imm_value, Funct, RD, ALU_OP,
            MemtoReg, RegWrite, Branch, MemWrite, MemRead, ALUSrc} = din;
    assign dout = {PC_Stored, Read_Data_1_S, Read_Data_2_S, imm_value_S, Funct_S, RD_S, ALU_OP_S,
                   MemtoReg_S, RegWrite_S, Branch_S, MemWrite_S, MemRead_S, ALUSrc_S};

    id_ex_skid_reg #(
        .XLEN(XLEN), .FUNCT_W(FUNCT_W), .RD_W(RD_W), .ALUOP_W(ALUOP_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .PC(PC), .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .imm_value(imm_value),
        .Funct(Funct), .RD(RD), .ALU_OP(ALU_OP),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC_Stored(PC_Stored), .Read_Data_1_S(Read_Data_1_S), .Read_Data_2_S(Read_Data_2_S),
        .imm_value_S(imm_value_S), .Funct_S(Funct_S), .RD_S(RD_S), .ALU_OP_S(ALU_OP_S),
        .MemtoReg_S(MemtoReg_S), .RegWrite_S(RegWrite_S), .Branch_S(Branch_S),
        .MemWrite_S(MemWrite_S), .MemRead_S(MemRead_S), .ALUSrc_S(ALUSrc_S),
        .occupancy(occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_bundle();
        logic [PW-1:0] v;
        v = '0;
        for (int i = 0; i < (PW + 31) / 32; i++)
            v = (v << 32) | PW'($urandom);
        return v;
    endfunction

    function automatic logic [PW-1:0] with_pc(input logic [XLEN-1:0] pc, input logic reg_write);
        logic [PW-1:0] v;
        v = rand_bundle();
        v[PW-1 -: XLEN] = pc;
        v[4] = reg_write;
        return v;
    endfunction

    // One clock of stimulus: drive, check in_ready before the edge, advance model, check outputs.
    task automatic cycle(input logic r, input logic f, input logic iv, input logic orr,
                         input logic [PW-1:0] d);
        logic acc, fr;
        logic [PW-1:0] exp;
        reset = r; flush = f; in_valid = iv; out_ready = orr; din = d;
        #1;
        check("in_ready", CW'(in_ready), CW'((q.size() < 2) && !r));
        @(posedge clk);
        if (r) begin
            q.delete();
            last_shown = '0;
        end else if (f) begin
            q.delete();
        end else begin
            acc = iv && (q.size() < 2);
            fr  = (q.size() > 0) && orr;
            if (fr) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        if (q.size() > 0) last_shown = q[0];
        #1;
        exp = last_shown;
        if (q.size() == 0) exp[4:1] = '0;
        check("out_valid", CW'(out_valid), CW'(q.size() > 0));
        check("occupancy", CW'(occupancy), CW'(q.size()));
        check("illegal_state", CW'(!out_valid && (occupancy != 2'd0)), CW'(0));
        check("payload", CW'(dout), CW'(exp));
        $display("t=%0t r=%0d f=%0d iv=%0d ordy=%0d -> ov=%0d occ=%0d pc=%h",
                 $time, r, f, iv, orr, out_valid, occupancy, PC_Stored);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;

        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, with_pc(64'h55, 1'b1));
            check("rst_regwrite", CW'(RegWrite_S), CW'(0));
            check("rst_pc", CW'(PC_Stored), CW'(0));
        end

        // Streaming at full throughput
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, with_pc(64'h100 + 64'(4 * i), 1'b1));
            check("stream_pc", CW'(PC_Stored), CW'(64'h100 + 64'(4 * i)));
            check("stream_occ", CW'(occupancy <= 2'd1), CW'(1));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Back-pressure into FULL, then drain
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h200, 1'b1));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h204, 1'b1));
        check("bp_occ", CW'(occupancy), CW'(2));
        check("bp_pc", CW'(PC_Stored), CW'(64'h200));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h208, 1'b1));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("drain_pc0", CW'(PC_Stored), CW'(64'h204));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("drain_empty", CW'(out_valid), CW'(0));

        // Flush in FULL together with a new bundle
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h300, 1'b1));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h304, 1'b1));
        cycle(1'b0, 1'b1, 1'b1, 1'b1, with_pc(64'h3F0, 1'b1));
        check("flush_regwrite", CW'(RegWrite_S), CW'(0));
        check("flush_memwrite", CW'(MemWrite_S), CW'(0));
        check("flush_hidden", CW'(PC_Stored != 64'h3F0), CW'(1));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

        // Reset beats flush in FULL
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h400, 1'b1));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, with_pc(64'h404, 1'b1));
        cycle(1'b1, 1'b1, 1'b1, 1'b1, with_pc(64'h408, 1'b1));
        check("rstpri_payload", CW'(dout), CW'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(255, 0) == 0),
                  ($urandom_range(15, 0) == 0),
                  ($urandom_range(9, 0) < 7),
                  ($urandom_range(9, 0) < 6),
                  rand_bundle());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
